gfx_vram_writer: RTL



---
 rtl/gfx_vram_writer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gfx_vram_writer.sv
// CPU-side VRAM writer: queues byte writes and commits each one in a cycle the
// scan-out reader leaves the VRAM bus free. Includes a constant-fill engine for screen clear.
module gfx_vram_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ctrl_ce_b,
  input  logic        i_ctrl_w_b,
  input  logic [2:0]  i_ctrl_addr,
  input  logic [7:0]  i_ctrl_data,
  input  logic        i_free_vbus,
  output logic [15:0] o_vaddr,
  output logic [7:0]  o_vdata,
  output logic        o_vwe_b,
  output logic        o_busy,
  output logic        o_fifo_full,
  output logic        o_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          w_q;
  logic [15:0]   ptr, ptr_nxt, ptr_step;
  logic [7:0]    incr, incr_nxt;
  logic [15:0]   fill_len, fill_len_nxt;
  logic [7:0]    fill_val, fill_val_nxt;
  logic [15:0]   remaining, remaining_nxt;
  logic          err, err_nxt;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [CW-1:0] count, count_nxt;
  logic [23:0]   mem [FIFO_DEPTH];

  logic          wr_ev, full, grant, push, drop, err_clr, abort;
  logic [7:0]    push_data;

  // One register event per falling CPU strobe.
  assign wr_ev    = ~i_ctrl_ce_b & ~i_ctrl_w_b & w_q;
  assign full     = (count == FULL_CNT);
  assign grant    = (count != '0) & i_free_vbus;
  assign ptr_step = ptr + {8'h00, incr};

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    incr_nxt      = incr;
    fill_len_nxt  = fill_len;
    fill_val_nxt  = fill_val;
    remaining_nxt = remaining;
    push          = 1'b0;
    push_data     = i_ctrl_data;
    drop          = 1'b0;
    err_clr       = 1'b0;
    abort         = 1'b0;

    if (wr_ev) begin
      if (i_ctrl_addr == 3'd7) begin
        err_clr = i_ctrl_data[0];
        if (i_ctrl_data[1] && state == FILL) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end else if (state == FILL) begin
        drop = 1'b1;
      end else begin
        case (i_ctrl_addr)
          3'd0: ptr_nxt[7:0]       = i_ctrl_data;
          3'd1: ptr_nxt[15:8]      = i_ctrl_data;
          3'd2: begin
            if (full) begin
              drop = 1'b1;
            end else begin
              push    = 1'b1;
              ptr_nxt = ptr_step;
            end
          end
          3'd3: incr_nxt           = i_ctrl_data;
          3'd4: fill_len_nxt[7:0]  = i_ctrl_data;
          3'd5: fill_len_nxt[15:8] = i_ctrl_data;
          3'd6: begin
            fill_val_nxt = i_ctrl_data;
            if (fill_len != 16'd0) begin
              remaining_nxt = fill_len;
              state_nxt     = FILL;
            end
          end
          default: ;
        endcase
      end
    end

    // The fill stalls rather than drops when the queue is full.
    if (state == FILL && !abort && !full) begin
      push          = 1'b1;
      push_data     = fill_val;
      ptr_nxt       = ptr_step;
      remaining_nxt = remaining - 16'd1;
      if (remaining == 16'd1) state_nxt = IDLE;
    end

    err_nxt = err;
    if (err_clr) err_nxt = 1'b0;
    if (drop)    err_nxt = 1'b1;

    case ({push, grant})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      w_q       <= 1'b1;
      ptr       <= 16'h0000;
      incr      <= 8'h01;
      fill_len  <= 16'h0000;
      fill_val  <= 8'h00;
      remaining <= 16'h0000;
      err       <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      w_q       <= i_ctrl_w_b;
      ptr       <= ptr_nxt;
      incr      <= incr_nxt;
      fill_len  <= fill_len_nxt;
      fill_val  <= fill_val_nxt;
      remaining <= remaining_nxt;
      err       <= err_nxt;
      count     <= count_nxt;
      if (push)  wr_idx <= wr_idx + AW'(1);
      if (grant) rd_idx <= rd_idx + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_idx] <= {ptr, push_data};
  end

  // Write pulse occupies the low half of a granted cycle.
  assign o_vaddr     = grant ? mem[rd_idx][23:8] : 'z;
  assign o_vdata     = grant ? mem[rd_idx][7:0]  : 'z;
  assign o_vwe_b     = ~(grant & ~i_clk);
  assign o_busy      = (count != '0) | (state == FILL);
  assign o_fifo_full = full;
  assign o_err       = err;
endmodule
